// File: rtl/i2c_txn_if.sv
// i2c_txn_if: byte stream from the i2c_listen sniffer into the transaction
// decoder, and the decoded register-access strobe back out.
//   byte_in[8:0]  data [8:1] MSB-first, ack bit [0] (0=ACK, 1=NACK)
//   byte_ready    byte_in valid this cycle
//   sop / eot     START (or repeated START) / STOP pulses
//   txn_*         decoded transaction fields, strobed by txn_valid
//   txn_busy      a frame is open
//   txn_count / err_count  statistics (zero unless stats are built)
// Modports: master = stream source / transaction sink, slave = decoder.
interface i2c_txn_if;
  logic [8:0]  byte_in;
  logic        byte_ready;
  logic        sop;
  logic        eot;
  logic        txn_valid;
  logic [6:0]  txn_dev;
  logic        txn_rw;
  logic [7:0]  txn_reg;
  logic [7:0]  txn_data;
  logic        txn_busy;
  logic [15:0] txn_count;
  logic [7:0]  err_count;

  modport master (
    output byte_in, byte_ready, sop, eot,
    input  txn_valid, txn_dev, txn_rw, txn_reg, txn_data, txn_busy,
           txn_count, err_count
  );

  modport slave (
    input  byte_in, byte_ready, sop, eot,
    output txn_valid, txn_dev, txn_rw, txn_reg, txn_data, txn_busy,
           txn_count, err_count
  );
endinterface

// File: rtl/i2c_txn_decoder.sv
// i2c_txn_decoder: frames the per-byte stream of an I2C sniffer into
// register-level transactions (device, direction, register pointer, data),
// each emitted as a one-cycle txn_valid strobe one clock after its byte.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    i2c_txn_if.slave (byte stream in, transaction strobe out)
// Parameters:
//   DEV_ADDR   7-bit device address accepted by the filter
//   MATCH_ALL  1 = accept every device address
// Optional build macro I2C_TXN_STATS_EN: when defined, txn_count counts
// strobes (wrapping) and err_count counts aborted frames (saturating);
// otherwise both are tied to zero and no counters exist.
module i2c_txn_decoder #(
  parameter logic [6:0] DEV_ADDR  = 7'h4B,
  parameter bit         MATCH_ALL = 1'b0
) (
  input  logic     clk,
  input  logic     reset,
  i2c_txn_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_REG  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_READ = 3'd4;
  localparam logic [2:0] S_SKIP = 3'd5;

  logic [2:0] state_q, state_d;
  logic [7:0] reg_ptr_q, reg_ptr_d;
  logic [6:0] frame_dev_q, frame_dev_d;
  logic       valid_q, valid_d;
  logic [6:0] dev_q, dev_d;
  logic       rw_q, rw_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] data_q, data_d;
  logic       busy_q, busy_d;

  logic nack, addr_miss, frame_err;

  assign nack      = bus.byte_in[0];
  assign addr_miss = !MATCH_ALL && (bus.byte_in[8:2] != DEV_ADDR);
  // Byte that aborts the frame: NACKed/foreign address, or NACKed pointer.
  assign frame_err = bus.byte_ready &&
                     (((state_q == S_ADDR) && (nack || addr_miss)) ||
                      ((state_q == S_REG) && nack));

  always_comb begin
    state_d     = state_q;
    reg_ptr_d   = reg_ptr_q;
    frame_dev_d = frame_dev_q;
    valid_d     = 1'b0;
    dev_d       = dev_q;
    rw_d        = rw_q;
    reg_d       = reg_q;
    data_d      = data_q;

    if (bus.byte_ready) begin
      case (state_q)
        S_ADDR: begin
          frame_dev_d = bus.byte_in[8:2];
          if (frame_err)           state_d = S_SKIP;
          else if (bus.byte_in[1]) state_d = S_READ;
          else                     state_d = S_REG;
        end
        S_REG: begin
          reg_ptr_d = bus.byte_in[8:1];
          state_d   = nack ? S_SKIP : S_DATA;
        end
        S_DATA, S_READ: begin
          // Output fields only move on an emit, so they hold between strobes.
          valid_d   = 1'b1;
          dev_d     = frame_dev_q;
          rw_d      = (state_q == S_READ);
          reg_d     = reg_ptr_q;
          data_d    = bus.byte_in[8:1];
          reg_ptr_d = reg_ptr_q + 8'd1;
          if (nack) state_d = S_SKIP;
        end
        default: ;
      endcase
    end

    // Bus conditions override after the byte is consumed; sop beats eot.
    // reg_ptr survives both so a repeated-start read continues the pointer.
    if (bus.sop)      state_d = S_ADDR;
    else if (bus.eot) state_d = S_IDLE;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      reg_ptr_q   <= 8'd0;
      frame_dev_q <= 7'd0;
      valid_q     <= 1'b0;
      dev_q       <= 7'd0;
      rw_q        <= 1'b0;
      reg_q       <= 8'd0;
      data_q      <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_ptr_q   <= reg_ptr_d;
      frame_dev_q <= frame_dev_d;
      valid_q     <= valid_d;
      dev_q       <= dev_d;
      rw_q        <= rw_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.txn_valid = valid_q;
  assign bus.txn_dev   = dev_q;
  assign bus.txn_rw    = rw_q;
  assign bus.txn_reg   = reg_q;
  assign bus.txn_data  = data_q;
  assign bus.txn_busy  = busy_q;

`ifdef I2C_TXN_STATS_EN
  logic [15:0] txn_cnt_q, txn_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    txn_cnt_d = txn_cnt_q + {15'd0, valid_d};
    err_cnt_d = err_cnt_q;
    // Count only a real entry to SKIP; a coincident sop/eot redirects it.
    if (frame_err && (state_d == S_SKIP) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      txn_cnt_q <= 16'd0;
      err_cnt_q <= 8'd0;
    end else begin
      txn_cnt_q <= txn_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.txn_count = txn_cnt_q;
  assign bus.err_count = err_cnt_q;
`else
  assign bus.txn_count = 16'd0;
  assign bus.err_count = 8'd0;
`endif

endmodule

// File: tb/tb_i2c_txn_decoder.sv
// Randomized frame-level bench: each frame is a list of bytes, its expected
// strobes are derived from the framing rules, then the bytes are played into
// the decoder and every strobe is matched against the expectation queue.
module tb_i2c_txn_decoder;
  localparam logic [6:0] DEV = 7'h4B;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  i2c_txn_if bus ();
  i2c_txn_if bus_all ();

  i2c_txn_decoder #(.DEV_ADDR(DEV), .MATCH_ALL(1'b0)) u_dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  i2c_txn_decoder #(.DEV_ADDR(DEV), .MATCH_ALL(1'b1)) u_all (
    .clk(clk), .reset(reset), .bus(bus_all.slave));

  assign bus_all.byte_in    = bus.byte_in;
  assign bus_all.byte_ready = bus.byte_ready;
  assign bus_all.sop        = bus.sop;
  assign bus_all.eot        = bus.eot;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         due;
    logic [6:0] dev;
    logic       rw;
    logic [7:0] r;
    logic [7:0] d;
  } exp_t;
  exp_t expq[$];

  // Matching-all instance: count its strobes for the filter test.
  int all_cnt = 0;
  always @(negedge clk) if (bus_all.txn_valid) all_cnt <= all_cnt + 1;

  // Monitor
  always @(negedge clk) begin
    if (bus.txn_valid) begin
      if (expq.size() == 0) chk("spurious_valid", bus.txn_valid, 1'b0);
      else begin
        exp_t e;
        e = expq.pop_front();
        chk("latency", cyc, e.due);
        chk("txn_dev", bus.txn_dev, e.dev);
        chk("txn_rw", bus.txn_rw, e.rw);
        chk("txn_reg", bus.txn_reg, e.r);
        chk("txn_data", bus.txn_data, e.d);
      end
    end else if (expq.size() > 0 && expq[0].due <= cyc) begin
      chk("missing_valid", bus.txn_valid, 1'b1);
      void'(expq.pop_front());
    end
  end

  // Reference model state
  logic [7:0]  m_ptr = 8'd0;
  logic [15:0] m_txn = 16'd0;
  logic [7:0]  m_err = 8'd0;
  logic [7:0]  fd[16];
  logic        fa[16];
  int          fn;
  logic        em[16];
  logic [7:0]  er[16];
  logic [6:0]  edev;
  logic        erw;
  int          err_idx;
  bit          open_by_sop = 0;

  // Walk the frame's byte list: address, then pointer (write) or data.
  task automatic model_frame();
    for (int i = 0; i < 16; i++) em[i] = 1'b0;
    err_idx = -1;
    edev = fd[0][7:1];
    erw  = fd[0][0];
    if (fa[0] || edev != DEV) err_idx = 0;
    else if (!erw) begin
      if (fn >= 2) begin
        m_ptr = fd[1];
        if (fa[1]) err_idx = 1;
        else begin
          for (int i = 2; i < fn; i++) begin
            em[i] = 1'b1; er[i] = m_ptr; m_ptr = m_ptr + 8'd1;
            if (fa[i]) break;
          end
        end
      end
    end else begin
      for (int i = 1; i < fn; i++) begin
        em[i] = 1'b1; er[i] = m_ptr; m_ptr = m_ptr + 8'd1;
        if (fa[i]) break;
      end
    end
  endtask

  task automatic drive(input logic br, input logic [7:0] d, input logic a,
                       input logic s, input logic e);
    bus.byte_ready = br;
    bus.byte_in    = {d, a};
    bus.sop        = s;
    bus.eot        = e;
  endtask

  task automatic cycle(input logic br, input logic [7:0] d, input logic a,
                       input logic s, input logic e);
    @(negedge clk);
    drive(br, d, a, s, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
  endtask

  // term: 0 eot after, 1 separate sop after, 2 sop with last byte, 3 eot with last byte
  task automatic run_frame(input int term_in);
    int term;
    term = term_in;
    model_frame();
    if (err_idx == fn - 1 && term >= 2) term = term - 2;
    if (err_idx >= 0 && m_err != 8'hFF) m_err = m_err + 8'd1;
    if (!open_by_sop) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    open_by_sop = 0;
    idle($urandom_range(0, 1));
    @(negedge clk);
    chk("busy_open", bus.txn_busy, 1'b1);
    for (int i = 0; i < fn; i++) begin
      if (i > 0) begin
        idle($urandom_range(0, 1));
        @(negedge clk);
      end
      drive(1'b1, fd[i], fa[i], (i == fn - 1) && term == 2, (i == fn - 1) && term == 3);
      if (em[i]) begin
        exp_t e;
        e.due = cyc + 1; e.dev = edev; e.rw = erw; e.r = er[i]; e.d = fd[i];
        expq.push_back(e);
        m_txn = m_txn + 16'd1;
      end
    end
    if (term == 0) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    if (term == 1) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    if (term == 1 || term == 2) open_by_sop = 1;
    idle(1);
    if (term == 0 || term == 3) chk("busy_closed", bus.txn_busy, 1'b0);
  endtask

  task automatic set_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] b4, input logic [3:0] nacks);
    fn = n;
    fd[0] = b0; fd[1] = b1; fd[2] = b2; fd[3] = b3; fd[4] = b4;
    for (int i = 0; i < 5; i++) fa[i] = (i < 4) ? nacks[i] : 1'b0;
  endtask

  task automatic chk_stats(input string tag);
`ifdef I2C_TXN_STATS_EN
    chk({tag, "_txn_count"}, bus.txn_count, m_txn);
    chk({tag, "_err_count"}, bus.err_count, m_err);
`else
    chk({tag, "_txn_count"}, bus.txn_count, 16'd0);
    chk({tag, "_err_count"}, bus.err_count, 8'd0);
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, bus.txn_valid, 1'b0);
    chk({tag, "_busy"}, bus.txn_busy, 1'b0);
    chk({tag, "_rw"}, bus.txn_rw, 1'b0);
    chk({tag, "_dev"}, bus.txn_dev, 7'd0);
    chk({tag, "_reg"}, bus.txn_reg, 8'd0);
    chk({tag, "_data"}, bus.txn_data, 8'd0);
    chk({tag, "_txn_count"}, bus.txn_count, 16'd0);
    chk({tag, "_err_count"}, bus.err_count, 8'd0);
  endtask

  int n0;

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    idle(2);

    // Single write: dev 0x4B W, reg 0x10, data 0xA5
    set_frame(3, 8'h96, 8'h10, 8'hA5, 8'h00, 8'h00, 4'b0000);
    run_frame(0);
    chk("wr_hold_reg", bus.txn_reg, 8'h10);
    chk("wr_hold_data", bus.txn_data, 8'hA5);

    // Burst wrap: reg 0xFE, data 01 02 03 -> regs FE FF 00
    set_frame(5, 8'h96, 8'hFE, 8'h01, 8'h02, 8'h03, 4'b0000);
    run_frame(0);
    chk("wrap_reg", bus.txn_reg, 8'h00);

    // Repeated-start read: write ptr 0x20, restart, read 5A, C3(NACK), extra ignored
    set_frame(2, 8'h96, 8'h20, 8'h00, 8'h00, 8'h00, 4'b0000);
    run_frame(1);
    set_frame(4, 8'h97, 8'h5A, 8'hC3, 8'hEE, 8'h00, 4'b0100);
    run_frame(0);
    chk("rd_last_reg", bus.txn_reg, 8'h21);
    chk("rd_last_rw", bus.txn_rw, 1'b1);

    // Filter: dev 0x50 rejected here, accepted by the match-all instance
    n0 = all_cnt;
    set_frame(3, 8'hA0, 8'h10, 8'h55, 8'h00, 8'h00, 4'b0000);
    run_frame(0);
    idle(1);
    chk("matchall_cnt", all_cnt - n0, 1);
    chk("matchall_dev", bus_all.txn_dev, 7'h50);
    chk("matchall_data", bus_all.txn_data, 8'h55);
    chk_stats("filter");

    // Address NACK -> nothing emitted
    set_frame(3, 8'h96, 8'h10, 8'h55, 8'h00, 8'h00, 4'b0001);
    run_frame(0);

    // sop coincident with a data byte, next byte decodes as address
    set_frame(3, 8'h96, 8'h30, 8'h11, 8'h00, 8'h00, 4'b0000);
    run_frame(2);
    set_frame(3, 8'h96, 8'h31, 8'h22, 8'h00, 8'h00, 4'b0000);
    run_frame(3);

    // Randomized frames
    for (int f = 0; f < 60; f++) begin
      fn = $urandom_range(1, 6);
      for (int i = 0; i < fn; i++) begin
        fd[i] = 8'($urandom);
        fa[i] = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 3) != 0) fd[0][7:1] = DEV;
      if ($urandom_range(0, 9) != 0) fa[0] = 1'b0;
      run_frame((f == 59) ? 0 : int'($urandom_range(0, 3)));
      if (!open_by_sop && $urandom_range(0, 3) == 0) begin
        cycle(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
        idle(1);
      end
    end
    idle(3);
    chk("drain", expq.size(), 0);
    chk_stats("random");

    // Reset during DATA: strobe-bearing byte is discarded
    set_frame(4, 8'h96, 8'h40, 8'h77, 8'h00, 8'h00, 4'b0000);
    fn = 3;
    run_frame(1);
    @(negedge clk);
    drive(1'b1, 8'h96, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_zero("midreset");
    reset = 1'b1;
    m_ptr = 8'd0; m_txn = 16'd0; m_err = 8'd0; open_by_sop = 0;
    idle(2);
    chk("midreset_valid", bus.txn_valid, 1'b0);

    // After reset the pointer restarts at 0: read emits reg 0x00
    set_frame(2, 8'h97, 8'h3C, 8'h00, 8'h00, 8'h00, 4'b0010);
    run_frame(0);
    idle(2);
    chk("post_reset_reg", bus.txn_reg, 8'h00);
    chk("post_drain", expq.size(), 0);
    chk_stats("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
